// File: rtl/flux_interval_decoder.sv
// Flux interval decoder: times edge-to-edge intervals of a pulse stream,
// classifies them into 2T/3T/4T/long symbols and queues them in a FIFO.
//
// Ports:
//   clk_in       - clock, rising edge
//   rst_n        - asynchronous active-low reset
//   pulse_in     - flux pulse, one or more cycles high per transition
//   clr          - synchronous clear of overflow and glitch_count
//   sym_data     - head symbol: 00=2T 01=3T 10=4T 11=long/no flux
//   sym_valid    - FIFO holds at least one symbol
//   sym_ready    - consumer pops the head when sym_valid is high
//   overflow     - sticky, a symbol was dropped on a full FIFO
//   glitch_count - saturating count of edges rejected as too close
//   locked       - a reference edge is held (TRACK state)
module flux_interval_decoder #(
    parameter int unsigned MIN_GAP = 30,
    parameter int unsigned T2_MAX  = 50,
    parameter int unsigned T3_MAX  = 70,
    parameter int unsigned T4_MAX  = 90,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       pulse_in,
    input  logic       clr,
    output logic [1:0] sym_data,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic       overflow,
    output logic [7:0] glitch_count,
    output logic       locked
);
    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam logic [9:0] MIN_GAP_C = 10'(MIN_GAP);
    localparam logic [9:0] T2_C      = 10'(T2_MAX);
    localparam logic [9:0] T3_C      = 10'(T3_MAX);
    localparam logic [9:0] T4_C      = 10'(T4_MAX);
    localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic       p1_q, p2_q;
    logic       flux_edge;
    logic       push_q, push_d;
    logic [1:0] psym_q, psym_d;
    logic       glitch_ev;
    logic [7:0] glitch_q, glitch_d;
    logic       ovf_q, ovf_d;
    logic [1:0] mem_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] count_q, count_d;
    logic       pop, full, wr_en, ovf_ev;

    function automatic logic [1:0] classify(input logic [9:0] iv);
        if (iv <= T2_C)      return 2'b00;
        else if (iv <= T3_C) return 2'b01;
        else if (iv <= T4_C) return 2'b10;
        else                 return 2'b11;
    endfunction

    // Rising edge of the doubly registered pulse; long pulses give one edge.
    assign flux_edge = p1_q & ~p2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q >= TIMEOUT_C) ? TIMEOUT_C : cnt_q + 10'd1;
        push_d    = 1'b0;
        psym_d    = 2'b00;
        glitch_ev = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flux_edge) begin
                    state_d = TRACK;
                    cnt_d   = 10'd1;
                end
            end
            TRACK: begin
                // An edge beats a coincident timeout.
                if (flux_edge) begin
                    if (cnt_q < MIN_GAP_C) begin
                        glitch_ev = 1'b1;
                    end else begin
                        push_d = 1'b1;
                        psym_d = classify(cnt_q);
                        cnt_d  = 10'd1;
                    end
                end else if (cnt_q + 10'd1 == TIMEOUT_C) begin
                    push_d  = 1'b1;
                    psym_d  = 2'b11;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        glitch_d = glitch_q;
        if (glitch_ev) begin
            if (clr)                   glitch_d = 8'd1;
            else if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
        end else if (clr) begin
            glitch_d = 8'd0;
        end
    end

    // The pop only applies to a non-empty FIFO, so a full FIFO that
    // pops in the same cycle still has room for the incoming symbol.
    always_comb begin
        pop     = (count_q != 3'd0) & sym_ready;
        full    = (count_q == 3'd4);
        wr_en   = push_q & (~full | pop);
        ovf_ev  = push_q & full & ~pop;
        count_d = count_q + {2'b00, wr_en} - {2'b00, pop};
        ovf_d   = ovf_ev | (ovf_q & ~clr);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 10'd0;
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            push_q   <= 1'b0;
            psym_q   <= 2'b00;
            glitch_q <= 8'd0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p1_q     <= pulse_in;
            p2_q     <= p1_q;
            push_q   <= push_d;
            psym_q   <= psym_d;
            glitch_q <= glitch_d;
            ovf_q    <= ovf_d;
            count_q  <= count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= psym_q;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
        end
    end

    assign sym_data     = mem_q[rd_ptr_q];
    assign sym_valid    = (count_q != 3'd0);
    assign overflow     = ovf_q;
    assign glitch_count = glitch_q;
    assign locked       = (state_q == TRACK);

endmodule

// File: tb/tb_flux_interval_decoder.sv
// Bench for flux_interval_decoder: interval-level reference model compared
// every cycle, directed scenarios with literal symbol lists, random traffic.
module tb_flux_interval_decoder;
    localparam int MIN_GAP = 30;
    localparam int T2_MAX  = 50;
    localparam int T3_MAX  = 70;
    localparam int T4_MAX  = 90;
    localparam int TIMEOUT = 255;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       pulse_in = 1'b0;
    logic       clr = 1'b0;
    logic       sym_ready = 1'b0;
    logic [1:0] sym_data;
    logic       sym_valid;
    logic       overflow;
    logic [7:0] glitch_count;
    logic       locked;

    flux_interval_decoder dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .pulse_in     (pulse_in),
        .clr          (clr),
        .sym_data     (sym_data),
        .sym_valid    (sym_valid),
        .sym_ready    (sym_ready),
        .overflow     (overflow),
        .glitch_count (glitch_count),
        .locked       (locked)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Reference model state: timestamps of edges, a symbol queue.
    int q[$];
    int m_got[$];
    int got[$];
    int sched[$];
    int exp_q[$];
    bit m_trk, m_edge, m_last, m_push;
    int m_sym, m_ref, m_t, m_ovf, m_gl;

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int sym_of(int iv);
        if (iv <= T2_MAX) return 0;
        if (iv <= T3_MAX) return 1;
        if (iv <= T4_MAX) return 2;
        return 3;
    endfunction

    // Applies the rules to the posedge that just passed, using the
    // inputs that were held across it.
    task automatic advance();
        bit pop, np, gev, ovf_ev;
        int ns, iv;
        if (!rst_n) begin
            m_trk = 0; m_edge = 0; m_last = 0; m_push = 0;
            m_sym = 0; m_ref = 0; m_t = 0; m_ovf = 0; m_gl = 0;
            q.delete();
            return;
        end
        m_t++;
        pop = (q.size() != 0) && sym_ready;
        ovf_ev = 0;
        if (pop) begin
            m_got.push_back(q[0]);
            void'(q.pop_front());
        end
        if (m_push) begin
            if (q.size() == 4) ovf_ev = 1;
            else q.push_back(m_sym);
        end
        if (ovf_ev) m_ovf = 1;
        else if (clr) m_ovf = 0;
        np = 0; ns = 0; gev = 0;
        if (m_edge) begin
            if (!m_trk) begin
                m_trk = 1;
                m_ref = m_t;
            end else begin
                iv = m_t - m_ref;
                if (iv < MIN_GAP) gev = 1;
                else begin
                    np = 1;
                    ns = sym_of(iv);
                    m_ref = m_t;
                end
            end
        end else if (m_trk && (m_t - m_ref == TIMEOUT - 1)) begin
            np = 1;
            ns = 3;
            m_trk = 0;
        end
        if (gev) m_gl = clr ? 1 : (m_gl < 255 ? m_gl + 1 : 255);
        else if (clr) m_gl = 0;
        m_push = np;
        m_sym = ns;
        m_edge = pulse_in && !m_last;
        m_last = pulse_in;
    endtask

    task automatic compare();
        chk("sym_valid", int'(sym_valid), int'(q.size() != 0));
        chk("locked", int'(locked), int'(m_trk));
        chk("overflow", int'(overflow), m_ovf);
        chk("glitch_count", int'(glitch_count), m_gl);
        if (q.size() != 0) chk("sym_data", int'(sym_data), q[0]);
    endtask

    task automatic step(logic p, logic r, logic c, logic rn);
        @(negedge clk_in);
        advance();
        compare();
        pulse_in = p;
        sym_ready = r;
        clr = c;
        rst_n = rn;
        if (rn && sym_valid && r) got.push_back(int'(sym_data));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", int'(sym_valid), 0);
        chk("rst_data", int'(sym_data), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_glitch", int'(glitch_count), 0);
        got.delete();
        m_got.delete();
    endtask

    function automatic bit in_sched(int n);
        foreach (sched[i]) if (sched[i] == n) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run(int n0, int n1, int rdy_from, int rst_at);
        for (int n = n0; n < n1; n++) begin
            logic rn;
            rn = !(rst_at >= 0 && n >= rst_at && n < rst_at + 2);
            step(in_sched(n), n >= rdy_from, 1'b0, rn);
        end
    endtask

    task automatic check_syms(string nm);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk({nm, "_count"}, got.size(), exp_q.size());
        chk({nm, "_model_count"}, m_got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({nm, "_sym"}, got[i], exp_q[i]);
        for (int i = 0; i < exp_q.size() && i < m_got.size(); i++)
            chk({nm, "_model_sym"}, m_got[i], exp_q[i]);
    endtask

    function automatic int pick_gap(int w);
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 2) return int'($urandom_range(35, w + 1));
        if (k < 8) return int'($urandom_range(95, 28));
        if (k == 8) return int'($urandom_range(270, 240));
        return int'($urandom_range(400, 300));
    endfunction

    task automatic run_random(int ncyc);
        int nxt, w;
        bit slow;
        logic p, r, c, rn;
        nxt = 50; w = 0; slow = 0;
        for (int n = 0; n < ncyc; n++) begin
            if (n % 400 == 0) slow = ($urandom_range(0, 2) == 0);
            if (n == nxt) begin
                w = int'($urandom_range(3, 1));
                nxt = n + pick_gap(w);
            end
            p = (w > 0);
            if (w > 0) w--;
            if (slow) r = ($urandom_range(0, 9) == 0);
            else r = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 149) == 0);
            rn = (n % 6000 != 5999);
            step(p, r, c, rn);
        end
    endtask

    initial begin
        // Intervals 40, 60, 80, 50 with lock visible from cycle 102.
        do_reset();
        sched = '{100, 140, 200, 280, 330};
        run(0, 102, 0, -1);
        chk("a_locked_101", int'(locked), 0);
        run(102, 103, 0, -1);
        chk("a_locked_102", int'(locked), 1);
        run(103, 400, 0, -1);
        exp_q = '{0, 1, 2, 0};
        check_syms("a_syms");

        // Edge 15 cycles after the reference is a glitch.
        do_reset();
        sched = '{100, 115, 140};
        run(0, 200, 0, -1);
        chk("b_glitch", int'(glitch_count), 1);
        exp_q = '{0};
        check_syms("b_syms");

        // Single edge then silence: one long symbol, back to IDLE.
        do_reset();
        sched = '{100};
        run(0, 400, 0, -1);
        chk("c_locked", int'(locked), 0);
        exp_q = '{3};
        check_syms("c_syms");

        // Stalled consumer: fifth symbol dropped, clr clears overflow.
        do_reset();
        sched = '{100, 140, 180, 220, 260, 300};
        run(0, 320, 100000, -1);
        chk("d_overflow", int'(overflow), 1);
        chk("d_model_depth", q.size(), 4);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("d_overflow_clr", int'(overflow), 0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        exp_q = '{0, 0, 0, 0};
        check_syms("d_syms");

        // Push and pop together while full: no overflow, order kept.
        do_reset();
        sched = '{100, 140, 200, 280, 330, 395};
        run(0, 430, 397, -1);
        chk("e_overflow", int'(overflow), 0);
        exp_q = '{0, 1, 2, 0, 1};
        check_syms("e_syms");

        // Class boundaries, edge coinciding with timeout, late glitch.
        do_reset();
        sched = '{100, 130, 180, 231, 301, 372, 462, 553, 807, 836, 867};
        run(0, 900, 0, -1);
        chk("s_glitch", int'(glitch_count), 1);
        chk("s_locked", int'(locked), 1);
        exp_q = '{0, 0, 1, 1, 2, 2, 3, 3, 1};
        check_syms("s_syms");

        // Reset between edges: the next edge only re-locks.
        do_reset();
        sched = '{100, 140};
        run(0, 200, 0, 120);
        chk("f_locked", int'(locked), 1);
        exp_q = '{};
        check_syms("f_syms");

        do_reset();
        run_random(20000);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
